// File: rtl/prize_score_conditioner.sv
// rtl/prize_score_conditioner.sv - prize-chute break-beam conditioner producing one stretched score pulse per prize
//
// Purpose:
//   Synchronizes and debounces the raw break-beam sensor, gates it with
//   i_game_active, emits one PULSE_CYCLES-wide score pulse per prize, then
//   locks out and waits for a clean release so a bouncing or held prize
//   scores only once. Keeps a saturating count of pulses issued.
//
// Ports:
//   i_clock          system clock, all state on posedge
//   i_reset          asynchronous, active-high reset
//   i_sensor_raw     asynchronous break-beam input
//   i_game_active    synchronous game-running qualifier
//   o_score_pulse    registered, PULSE_CYCLES wide
//   o_score_strobe   registered, one cycle, first cycle of o_score_pulse
//   o_busy           high whenever the FSM is not IDLE
//   o_event_count    registered saturating count of pulses issued
//   o_glitch_count   saturating count of sensor-release aborts during QUALIFY
//                    (present only when PRIZE_GLITCH_CNT_EN is defined)
//
// Build option: PRIZE_GLITCH_CNT_EN

module prize_score_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned PULSE_CYCLES      = 4,
  parameter int unsigned LOCKOUT_CYCLES    = 50_000_000,
  parameter bit          SENSOR_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_sensor_raw,
  input  logic        i_game_active,
  output logic        o_score_pulse,
  output logic        o_score_strobe,
  output logic        o_busy,
  output logic [15:0] o_event_count
`ifdef PRIZE_GLITCH_CNT_EN
  ,
  output logic [7:0]  o_glitch_count
`endif
);

  localparam int unsigned MAX_DP  = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_DP > LOCKOUT_CYCLES) ? MAX_DP : LOCKOUT_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);

  // Raw level that means "beam intact"; the synchronizer resets to it so
  // leaving reset can never look like a prize.
  localparam logic SYNC_IDLE = SENSOR_ACTIVE_LOW;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_QUALIFY      = 3'd1,
    ST_FIRE         = 3'd2,
    ST_LOCKOUT      = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_sync1;
  logic               r_sync2;
  logic               w_sensor_act;
  logic               w_fire_entry;
  logic               r_score_pulse;
  logic               r_score_strobe;
  logic [15:0]        r_event_count;

  // Two-flop synchronizer for the asynchronous sensor.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= SYNC_IDLE;
      r_sync2 <= SYNC_IDLE;
    end else begin
      r_sync1 <= i_sensor_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sensor_act = r_sync2 ^ SENSOR_ACTIVE_LOW;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A single counter is shared by every timed state; each transition
  // reloads it to zero so the next state starts its own interval.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_sensor_act && i_game_active) begin
          w_state_next = ST_QUALIFY;
          w_cnt_next   = '0;
        end
      end
      ST_QUALIFY: begin
        if (!w_sensor_act || !i_game_active) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = ST_FIRE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      // FIRE ignores both sensor and game_active: a pulse is never truncated.
      ST_FIRE: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_next = ST_LOCKOUT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (r_cnt == LOCK_LAST) begin
          w_state_next = ST_WAIT_RELEASE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      // Needs an unbroken run of released samples; a held prize parks here.
      ST_WAIT_RELEASE: begin
        if (w_sensor_act) begin
          w_cnt_next = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_fire_entry = (r_state != ST_FIRE) && (w_state_next == ST_FIRE);

  // Outputs are registered from the next state so the pulse rises on the
  // same edge that enters FIRE and falls on the edge that leaves it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_score_pulse  <= 1'b0;
      r_score_strobe <= 1'b0;
      r_event_count  <= '0;
    end else begin
      r_score_pulse  <= (w_state_next == ST_FIRE);
      r_score_strobe <= w_fire_entry;
      if (w_fire_entry && (r_event_count != 16'hFFFF)) begin
        r_event_count <= r_event_count + 16'd1;
      end
    end
  end

  assign o_score_pulse  = r_score_pulse;
  assign o_score_strobe = r_score_strobe;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_event_count  = r_event_count;

`ifdef PRIZE_GLITCH_CNT_EN
  logic       w_glitch;
  logic [7:0] r_glitch_count;

  // Only a sensor release inside QUALIFY counts; game_active aborts do not.
  assign w_glitch = (r_state == ST_QUALIFY) && !w_sensor_act;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_glitch_count <= '0;
    end else if (w_glitch && (r_glitch_count != 8'hFF)) begin
      r_glitch_count <= r_glitch_count + 8'd1;
    end
  end

  assign o_glitch_count = r_glitch_count;
`endif

endmodule
